incdec_sequencer: RTL and testbench

- Command-side controller for an external load/inc/dec counter with a one-cycle update latency.
- On `start`, it loads an initial value into the counter, then issues single inc or dec steps until the counter's fed-back output reaches a limit.
- It ends each run with a `done` pulse, plus an error flag if the next step would wrap.
- It sits between loop-control logic and the counter macrocell and drives that counter's `enable`/`load`/`inc`/`dec`/`i0` pins directly.

---
 rtl/incdec_sequencer.sv | 135 +++++++++++++
 tb/tb_incdec_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/incdec_sequencer.sv
// incdec_sequencer: command-side controller for an external load/inc/dec
// counter with one-cycle update latency. A run loads init into the counter,
// then issues single inc/dec steps (at most one per two cycles) until the
// fed-back count reaches limit, or until the next step would wrap.
//
// Handshake: start is a level sampled only in IDLE; done is a one-cycle
// pulse with err/result/step_cnt valid in the same cycle. abort cancels a
// run at the next edge without a done pulse.
module incdec_sequencer #(
    parameter int          width   = 32,
    parameter int unsigned countby = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic [width-1:0] init,
    input  logic [width-1:0] limit,
    input  logic             stall,
    input  logic [width-1:0] cnt_o0,
    output logic             cnt_enable,
    output logic             cnt_load,
    output logic             cnt_inc,
    output logic             cnt_dec,
    output logic [width-1:0] cnt_i0,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [width-1:0] result,
    output logic [width-1:0] step_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Step size at counter width, and the largest value that can still be
    // incremented without wrapping.
    localparam logic [width-1:0] STEP    = width'(countby);
    localparam logic [width-1:0] UP_WRAP = {width{1'b1}} - STEP;

    state_t           state;
    logic [width-1:0] init_q;
    logic [width-1:0] limit_q;
    logic             dir_q;
    logic             term;
    logic             wrap;
    logic             step;

    // Termination / wrap evaluation on the fed-back count; the step is Mealy
    // so the command lands in the same CHECK cycle it is decided.
    always_comb begin
        term = 1'b0;
        wrap = 1'b0;
        if (dir_q) begin
            term = (cnt_o0 >= limit_q);
            wrap = (cnt_o0 > UP_WRAP);
        end else begin
            term = (cnt_o0 <= limit_q);
            wrap = (cnt_o0 < STEP);
        end
        step = (state == S_CHECK) && !term && !wrap && !stall;
    end

    assign cnt_load   = (state == S_LOAD);
    assign cnt_enable = cnt_load | step;
    assign cnt_inc    = step & dir_q;
    assign cnt_dec    = step & ~dir_q;
    assign cnt_i0     = init_q;
    assign dbg_state  = state;

    // Sequencer FSM with registered busy/done/err/result/step_cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            init_q   <= '0;
            limit_q  <= '0;
            dir_q    <= 1'b0;
            result   <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            init_q   <= init;
                            limit_q  <= limit;
                            dir_q    <= dir;
                            step_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD:   state <= S_SETTLE;
                    S_SETTLE: state <= S_CHECK;
                    S_CHECK: begin
                        if (term || wrap) begin
                            result <= cnt_o0;
                            err    <= !term;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (!stall) begin
                            if (step_cnt != {width{1'b1}}) begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                            state <= S_SETTLE;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_incdec_sequencer.sv
// Bench for incdec_sequencer (width 8, countby 3) with a behavioural
// load/inc/dec counter attached, a run-level reference model and a
// scoreboard checked on every done pulse.
module tb_incdec_sequencer;

    localparam int W  = 8;
    localparam int CB = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, abort, dir, stall;
    logic [W-1:0] init, limit, cnt_o0;
    logic         cnt_enable, cnt_load, cnt_inc, cnt_dec;
    logic [W-1:0] cnt_i0, result, step_cnt;
    logic         busy, done, err;
    logic [2:0]   dbg_state;

    typedef struct {
        logic [W-1:0] result;
        logic         err;
        int           steps;
        int           lat;
        int           t0;
        logic [W-1:0] init;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         me;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_done = 0;
    int           loads = 0, cmds = 0, illegal = 0;
    bit           clr_mon = 1'b0;
    logic [W-1:0] last_result = '0;
    logic         last_err = 1'b0;
    logic [W-1:0] cnt = '0;

    incdec_sequencer #(.width(W), .countby(CB)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .dir(dir),
        .init(init), .limit(limit), .stall(stall), .cnt_o0(cnt_o0),
        .cnt_enable(cnt_enable), .cnt_load(cnt_load), .cnt_inc(cnt_inc),
        .cnt_dec(cnt_dec), .cnt_i0(cnt_i0), .busy(busy), .done(done),
        .err(err), .result(result), .step_cnt(step_cnt), .dbg_state(dbg_state)
    );

    // clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // behavioural counter: one-cycle latency, load wins over inc/dec
    always @(posedge clk) begin
        if (cnt_enable) begin
            if (cnt_load)     cnt <= cnt_i0;
            else if (cnt_inc) cnt <= cnt + W'(CB);
            else if (cnt_dec) cnt <= cnt - W'(CB);
        end
    end
    assign cnt_o0 = cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    endtask

    // run-level reference: walk the count in steps of CB until term or wrap
    function automatic void model(input logic [W-1:0] i, input logic [W-1:0] l, input logic d,
                                  output logic [W-1:0] r, output logic e, output int s);
        int v;
        v = int'(i);
        s = 0;
        e = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (d ? (v >= int'(l)) : (v <= int'(l))) begin e = 1'b0; break; end
            if (d ? (v > 255 - CB) : (v < CB))       begin e = 1'b1; break; end
            v = d ? v + CB : v - CB;
            s++;
        end
        r = W'(v);
    endfunction

    // monitor / scoreboard
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            loads = 0; cmds = 0; illegal = 0;
        end else begin
            if (clr_mon) begin
                loads = 0; cmds = 0; illegal = 0; clr_mon = 1'b0;
            end
            if (cnt_load) begin
                loads++;
                if (exp_q.size() > 0) chk("cnt_i0", 32'(cnt_i0), 32'(exp_q[0].init));
            end
            if (cnt_enable && (cnt_inc || cnt_dec)) cmds++;
            if ((cnt_load && (cnt_inc || cnt_dec)) || (cnt_inc && cnt_dec) ||
                ((cnt_inc || cnt_dec || cnt_load) && !cnt_enable))
                illegal++;
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    me = exp_q.pop_front();
                    chk("result",   32'(result),   32'(me.result));
                    chk("err",      32'(err),      32'(me.err));
                    chk("step_cnt", 32'(step_cnt), 32'(me.steps));
                    chk("latency",  32'(cyc - me.t0), 32'(me.lat));
                    chk("loads",    32'(loads),    32'(1));
                    chk("cmds",     32'(cmds),     32'(me.steps));
                    chk("illegal",  32'(illegal),  32'(0));
                end
            end
        end
    end

    // one complete run with optional stall window and ignored mid-run start
    task automatic run(input logic [W-1:0] i, input logic [W-1:0] l, input logic d,
                       input int slen, input bit bstart);
        exp_t e;
        int   s, nd0;
        bit   fin;
        fin = 1'b0;
        model(i, l, d, e.result, e.err, s);
        e.steps = s;
        e.lat   = 4 + 2 * s + ((s >= 2) ? slen : 0);
        e.init  = i;
        @(negedge clk);
        init = i; limit = l; dir = d; start = 1'b1; clr_mon = 1'b1;
        e.t0 = cyc;
        nd0  = n_done;
        exp_q.push_back(e);
        for (int k = 1; k < 700; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (bstart && k == 2) begin
                start = 1'b1; init = W'($urandom); limit = W'($urandom); dir = 1'($urandom);
            end
            if (bstart && k == 3) start = 1'b0;
            if (slen > 0 && k == 5) stall = 1'b1;
            if (slen > 0 && k == 5 + slen) stall = 1'b0;
            if (n_done != nd0 && k > 5 + slen) begin fin = 1'b1; break; end
        end
        if (!fin) begin
            chk("run_timeout", 32'(fin), 32'(1));
            exp_q.delete();
        end
        last_result = e.result;
        last_err    = e.err;
    endtask

    // start a long run, abort it in SETTLE, and expect no done
    task automatic abort_run();
        @(negedge clk);
        init = 8'd0; limit = 8'd200; dir = 1'b1; start = 1'b1; clr_mon = 1'b1;
        @(negedge clk); start = 1'b0;            // LOAD
        @(negedge clk); abort = 1'b1;            // SETTLE
        @(negedge clk); abort = 1'b0;            // expected IDLE
        chk("abort_busy",     32'(busy),      32'(0));
        chk("abort_state",    32'(dbg_state), 32'(0));
        chk("abort_result",   32'(result),    32'(last_result));
        chk("abort_err",      32'(err),       32'(last_err));
        chk("abort_step_cnt", 32'(step_cnt),  32'(0));
        repeat (12) @(negedge clk);
    endtask

    // start a long run and pulse reset in the middle of it
    task automatic reset_run();
        @(negedge clk);
        init = 8'd10; limit = 8'd100; dir = 1'b1; start = 1'b1; clr_mon = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy",    32'(busy),     32'(0));
        chk("rst_done",    32'(done),     32'(0));
        chk("rst_err",     32'(err),      32'(0));
        chk("rst_result",  32'(result),   32'(0));
        chk("rst_step",    32'(step_cnt), 32'(0));
        chk("rst_cmds",    32'({cnt_enable, cnt_load, cnt_inc, cnt_dec}), 32'(0));
        chk("rst_i0",      32'(cnt_i0),   32'(0));
        chk("rst_state",   32'(dbg_state), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        last_result = '0;
        last_err    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; stall = 1'b0;
        init = '0; limit = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   32'(busy),     32'(0));
        chk("reset_done",   32'(done),     32'(0));
        chk("reset_result", 32'(result),   32'(0));
        chk("reset_step",   32'(step_cnt), 32'(0));
        chk("reset_cmds",   32'({cnt_enable, cnt_load, cnt_inc, cnt_dec}), 32'(0));
        reset = 1'b1;
        @(negedge clk);

        run(8'd0,   8'd15,  1'b1, 0, 1'b0);  // 5 incs, done in cycle 14
        run(8'd20,  8'd10,  1'b0, 0, 1'b0);  // 20,17,14,11,8
        run(8'd250, 8'd255, 1'b1, 0, 1'b0);  // 250->253 then wrap
        run(8'd7,   8'd7,   1'b1, 0, 1'b0);  // already terminal
        run(8'd2,   8'd1,   1'b0, 0, 1'b0);  // down wrap with no step
        run(8'd0,   8'd15,  1'b1, 6, 1'b0);  // stall in second CHECK
        run(8'd0,   8'd15,  1'b1, 0, 1'b1);  // start while busy is ignored
        abort_run();
        run(8'd30,  8'd40,  1'b1, 0, 1'b0);
        reset_run();
        run(8'd255, 8'd0,   1'b0, 0, 1'b0);  // long down run to 0 overshoot check

        for (int r = 0; r < 25; r++) begin
            run(W'($urandom), W'($urandom), 1'($urandom),
                ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : 0,
                1'($urandom_range(0, 1)));
        end

        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
